// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and the golden ALU function for the ALU op sequencer and its bench.
package alu_seq_pkg;

  localparam int OPW_DEF  = 3;
  localparam int RESW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPW_DEF-1:0] a;
    logic [OPW_DEF-1:0] b;
    logic               sel;
  } cmd_t;

  // Reference result: operands zero-extended, result taken mod 2^RESW.
  function automatic logic [RESW_DEF-1:0] alu_expected(input logic [OPW_DEF-1:0] a,
                                                       input logic [OPW_DEF-1:0] b,
                                                       input logic               sel);
    logic [RESW_DEF-1:0] ae;
    logic [RESW_DEF-1:0] be;
    ae = RESW_DEF'(a);
    be = RESW_DEF'(b);
    return sel ? (ae - be) : (ae + be);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response channels of the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int OPW  = 3,
  parameter int RESW = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OPW-1:0]  cmd_a;
  logic [OPW-1:0]  cmd_b;
  logic            cmd_sel;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [OPW-1:0]  rsp_a;
  logic [OPW-1:0]  rsp_b;
  logic            rsp_sel;
  logic [RESW-1:0] rsp_result;
  logic            rsp_err;

  // Command source / response consumer side.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_a, rsp_b, rsp_sel, rsp_result, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    output cmd_ready, rsp_valid, rsp_a, rsp_b, rsp_sel, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous first-in first-out buffer of ALU commands.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer/occupancy; a push and a pop on the same edge leave count unchanged.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands, drives the ALU, captures its registered result and
// returns it with the operands and a self-check flag. OPW/RESW must match the
// package defaults because the command struct and golden function use them.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPW   = OPW_DEF,
  parameter int RESW  = RESW_DEF,
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                clock,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output logic [OPW-1:0]      alu_a,
  output logic [OPW-1:0]      alu_b,
  output logic                alu_sel,
  input  logic [RESW-1:0]     alu_result,
  output logic [ERRW-1:0]     err_count,
  output logic                busy
);

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : (v + ERRW'(1));
  endfunction

  state_e                 state_q, state_d;
  cmd_t                   cur_q, cur_d;
  logic [OPW-1:0]         alu_a_q, alu_a_d;
  logic [OPW-1:0]         alu_b_q, alu_b_d;
  logic                   alu_sel_q, alu_sel_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [OPW-1:0]         rsp_a_q, rsp_a_d;
  logic [OPW-1:0]         rsp_b_q, rsp_b_d;
  logic                   rsp_sel_q, rsp_sel_d;
  logic [RESW-1:0]        rsp_result_q, rsp_result_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [ERRW-1:0]        err_count_q, err_count_d;

  cmd_t                   fifo_din;
  cmd_t                   fifo_dout;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign fifo_din = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.cmd_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencing: IDLE pops, ISSUE lets the ALU sample, WAIT captures, RESP hands off.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_a_d      = rsp_a_q;
    rsp_b_d      = rsp_b_q;
    rsp_sel_d    = rsp_sel_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    err_count_d  = err_count_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      // Stage 0: take the oldest command and present it to the ALU.
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_d     = fifo_dout;
          alu_a_d   = fifo_dout.a;
          alu_b_d   = fifo_dout.b;
          alu_sel_d = fifo_dout.sel;
          state_d   = ISSUE;
        end
      end
      // Stage 1: ALU samples its inputs on this edge.
      ISSUE: state_d = WAIT;
      // Stage 2: ALU result is now registered; capture and self-check it.
      WAIT: begin
        rsp_result_d = alu_result;
        rsp_a_d      = cur_q.a;
        rsp_b_d      = cur_q.b;
        rsp_sel_d    = cur_q.sel;
        rsp_err_d    = (alu_result != alu_expected(cur_q.a, cur_q.b, cur_q.sel));
        rsp_valid_d  = 1'b1;
        if (rsp_err_d) err_count_d = sat_inc(err_count_q);
        state_d      = RESP;
      end
      // Stage 3: hold the response until the consumer takes it.
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_a_q      <= '0;
      rsp_b_q      <= '0;
      rsp_sel_q    <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_a_q      <= rsp_a_d;
      rsp_b_q      <= rsp_b_d;
      rsp_sel_q    <= rsp_sel_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      err_count_q  <= err_count_d;
    end
  end

  // In-flight command copy; only read after IDLE has loaded it.
  always_ff @(posedge clock) begin
    cur_q <= cur_d;
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_a      = rsp_a_q;
  assign bus.rsp_b      = rsp_b_q;
  assign bus.rsp_sel    = rsp_sel_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_sel        = alu_sel_q;
  assign err_count      = err_count_q;
  assign busy           = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side companion to the ALU datapath: buffers operation commands, drives the ALU's a/b/sel inputs, and captures the registered ALU result. It returns each result with its original operands and a self-check flag on a valid/ready response channel. It sits between a command source (testbench sequencer or control logic) and the ALU instance, and is also the team's reusable scoreboard-in-RTL for ALU bring-up.

Parameters:
OPW, 3, operand width (matches ALU a/b)
RESW, 4, result width (matches ALU result)
DEPTH, 4, command FIFO entries (power of two, >=2)
ERRW, 8, width of saturating error counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (= not full)
cmd_a  in  OPW  operand a
cmd_b  in  OPW  operand b
cmd_sel  in  1  0 = add, 1 = subtract
alu_a  out  OPW  to ALU a (registered)
alu_b  out  OPW  to ALU b (registered)
alu_sel  out  1  to ALU sel (registered)
alu_result  in  RESW  from ALU result (ALU registers it one edge after sampling)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_a, rsp_b  out  OPW  echoed operands
rsp_sel  out  1  echoed op
rsp_result  out  RESW  captured ALU result
rsp_err  out  1  rsp_result != expected
err_count  out  ERRW  saturating mismatch count
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (reset==0 at an edge): FIFO emptied; state IDLE; alu_a/alu_b/alu_sel = 0; rsp_valid = 0; rsp_* = 0; rsp_err = 0; err_count = 0; busy = 0; cmd_ready = 1 on the cycle after reset. Reset mid-operation discards all queued and in-flight commands; no response is emitted for them.
- Command accept: a push occurs when cmd_valid && cmd_ready at an edge. cmd_ready = !full and does not depend on a same-cycle pop. A push and a pop may occur on the same edge when the FIFO is not full; the count is then unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop, register alu_a/alu_b/alu_sel and an internal copy of the command, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: the ALU samples its inputs on this edge. Go to WAIT.
  - WAIT: on this edge, capture alu_result into rsp_result, copy the operands to rsp_a/rsp_b/rsp_sel, compute rsp_err, set rsp_valid = 1, go to RESP. If rsp_err = 1, err_count increments and saturates at all-ones.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- alu_* outputs hold their last values between operations and are never driven to X.
- Latency: a command pushed at edge E0 into an empty FIFO with the FSM in IDLE gives rsp_valid high after edge E3. Throughput is one operation per 4 cycles when rsp_ready is held at 1.
- Expected value is computed mod 2^RESW, with operands zero-extended:
  - add: a + b, maximum 14 for OPW=3, so it never wraps.
  - subtract: a - b, wraps, e.g. 0 - 7 = 4'h9 and 2 - 5 = 4'hD.
- The FIFO is ordered first-in first-out; responses are returned in command order.
- Back-pressure: while in RESP with rsp_ready low, the FIFO keeps accepting commands until full.

Decomposition:
- Package alu_seq_pkg contains:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - OPW/RESW default constants;
  - a cmd struct {a, b, sel};
  - function alu_expected(a, b, sel), returning RESW bits. The same function is reused by the bench scoreboard.
- Sub-module alu_cmd_fifo: synchronous FIFO with DEPTH entries holding the cmd struct; push/pop/full/empty/count; same synchronous active-low reset.

Test Plan:
- Single add: cmd a=3, b=4, sel=0, rsp_ready=1, with a correct ALU attached -> rsp_valid rises 3 edges after accept; rsp_result=7, rsp_err=0.
- Subtract wrap: a=2, b=5, sel=1 -> rsp_result=4'hD; then a=0, b=7, sel=1 -> 4'h9; a=7, b=7, sel=0 -> 4'hE; all rsp_err=0.
- Back-pressure/full: rsp_ready=0 and cmd_valid held with 6 distinct cmds -> exactly 5 accepted (1 in the FSM + 4 in the FIFO), then cmd_ready=0. Release rsp_ready -> 5 responses in order with rsp_* stable while stalled.
- Mismatch: force alu_result=4'h0 for cmd 3+4 -> rsp_err=1, err_count=1. Repeat 300 times -> err_count saturates at 255.
- Reset mid-op: push 3 cmds, assert reset for 1 cycle while in WAIT -> rsp_valid=0, busy=0, cmd_ready=1, err_count=0, and no stale responses afterwards.
- Simultaneous push/pop: FIFO holding 2 entries, push on the same edge as the IDLE pop -> count stays 2 and order is preserved.
